readout_shift_ctrl: RTL and testbench

- Sequencer that feeds the free-running serial-in/parallel-out shift_register (WIDTH bits, shifts every cycle, `load` captures the parallel word).
- Accepts CHUNK-bit words over a valid/ready stream and buffers them. Serializes each word MSB-first onto `shift_in`.
- After exactly WIDTH consecutive bits, pulses `load` so the shift register's `data_out` holds one complete frame.
- Sits between the pixel/readout data source and the shift_register instance.

---
 rtl/readout_pkg.sv | 20 ++
 rtl/chunk_fifo.sv | 55 +++++
 rtl/readout_shift_ctrl.sv | 145 ++++++++++++++
 tb/tb_readout_shift_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/readout_pkg.sv
// Shared definitions for the readout shift sequencer: controller state
// encoding, default geometry and a helper for counter sizing.
package readout_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    LOAD
  } state_t;

  localparam int unsigned DEF_WIDTH = 512;
  localparam int unsigned DEF_CHUNK = 8;
  localparam int unsigned DEF_CNT_W = 16;

  // Width of a down-counter spanning 0..w-1 (never narrower than one bit).
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/chunk_fifo.sv
// Two-entry FIFO buffering input words ahead of the serializer.
// Ports:
//   clk, reset_n  clock / asynchronous active-low reset
//   push, wdata   write request and data (ignored while full)
//   pop           read request (ignored while empty)
//   rdata         head-of-queue word (valid while !empty)
//   full, empty   occupancy flags
module chunk_fifo #(
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty
);

  logic [DW-1:0] mem [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    count;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= ~wr_ptr;
      if (pop_ok)  rd_ptr <= ~rd_ptr;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; contents are only observed while non-empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/readout_shift_ctrl.sv
// Sequencer feeding a free-running SIPO shift register. Buffers CHUNK-bit
// words, serializes them MSB-first on shift_in and strobes load right after
// the last of WIDTH bits so the shift register captures one full frame.
// Ports:
//   clk, reset_n            clock / asynchronous active-low reset
//   enable                  allows new frames to start
//   clr_status              clears underrun_flag (a new underrun wins)
//   in_data/in_valid/in_ready  word input stream
//   shift_in, load          serial bit and capture strobe to shift register
//   busy                    controller not idle
//   frame_done              pulse with load
//   underrun, underrun_flag abort pulse and sticky status
//   frame_count             completed frames, wrapping
module readout_shift_ctrl
  import readout_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CHUNK = DEF_CHUNK,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             clr_status,
  input  logic [CHUNK-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             shift_in,
  output logic             load,
  output logic             busy,
  output logic             frame_done,
  output logic             underrun,
  output logic             underrun_flag,
  output logic [CNT_W-1:0] frame_count
);

  localparam int unsigned BW = cnt_width(WIDTH);
  localparam int unsigned WB = cnt_width(CHUNK);
  localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);
  localparam logic [WB-1:0] WBIT_LAST = WB'(CHUNK - 1);

  if (WIDTH % CHUNK != 0) begin : g_bad_geometry
    $error("readout_shift_ctrl: WIDTH must be a multiple of CHUNK");
  end

  state_t           state, state_n;
  logic [BW-1:0]    bit_cnt, bit_cnt_n;
  logic [WB-1:0]    wbit, wbit_n;
  logic [CHUNK-1:0] word, word_n;
  logic             sin_n, load_n, und_n, pop;
  logic [CHUNK-1:0] head;
  logic             full, empty;

  // in_ready is held low while reset is asserted so every output reads 0.
  assign in_ready = ~full & reset_n;
  assign busy     = (state != IDLE);

  chunk_fifo #(.DW(CHUNK)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (in_valid && in_ready),
    .wdata   (in_data),
    .pop     (pop),
    .rdata   (head),
    .full    (full),
    .empty   (empty)
  );

  // Next-state values are computed for the *outputs* so that the registered
  // shift_in bit lines up with the cycle the state register says SHIFT.
  // bit_cnt and wbit index the bit currently on shift_in.
  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    wbit_n    = wbit;
    word_n    = word;
    load_n    = 1'b0;
    und_n     = 1'b0;
    pop       = 1'b0;
    case (state)
      IDLE, LOAD: begin
        state_n = IDLE;
        if (enable && !empty) begin
          pop       = 1'b1;
          word_n    = head;
          wbit_n    = WBIT_LAST;
          bit_cnt_n = BIT_LAST;
          state_n   = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_cnt == '0) begin
          state_n   = LOAD;
          load_n    = 1'b1;
          bit_cnt_n = BIT_LAST;
        end else if (wbit == '0) begin
          if (!empty) begin
            pop       = 1'b1;
            word_n    = head;
            wbit_n    = WBIT_LAST;
            bit_cnt_n = bit_cnt - BW'(1);
          end else begin
            und_n     = 1'b1;
            state_n   = IDLE;
            bit_cnt_n = BIT_LAST;
          end
        end else begin
          word_n    = word << 1;
          wbit_n    = wbit - WB'(1);
          bit_cnt_n = bit_cnt - BW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
    sin_n = (state_n == SHIFT) ? word_n[CHUNK-1] : 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      bit_cnt       <= BIT_LAST;
      wbit          <= WBIT_LAST;
      word          <= '0;
      shift_in      <= 1'b0;
      load          <= 1'b0;
      frame_done    <= 1'b0;
      underrun      <= 1'b0;
      underrun_flag <= 1'b0;
      frame_count   <= '0;
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      wbit       <= wbit_n;
      word       <= word_n;
      shift_in   <= sin_n;
      load       <= load_n;
      frame_done <= load_n;
      underrun   <= und_n;
      if (und_n)           underrun_flag <= 1'b1;
      else if (clr_status) underrun_flag <= 1'b0;
      if (load_n) frame_count <= frame_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_readout_shift_ctrl.sv
module tb_readout_shift_ctrl;

  localparam int unsigned W  = 16;
  localparam int unsigned C  = 8;
  localparam int unsigned CW = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          enable = 1'b0;
  logic          clr_status = 1'b0;
  logic [C-1:0]  in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready, shift_in, load, busy, frame_done, underrun, underrun_flag;
  logic [CW-1:0] frame_count;

  // Free-running SIPO shift register with parallel capture.
  logic [W-1:0]  sr = '0;
  logic [W-1:0]  data_out = '0;

  int vectors = 0;
  int miscompares = 0;
  logic [W-1:0] exp_q[$];

  int   cyc = 0, load_count = 0, und_count = 0, done_count = 0;
  int   last_load_cyc = 0, prev_load_cyc = 0, busy_drops = 0;
  bit   track_busy = 1'b0;
  logic load_d = 1'b0;

  always #5 clk = ~clk;

  readout_shift_ctrl #(.WIDTH(W), .CHUNK(C), .CNT_W(CW)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable        (enable),
    .clr_status    (clr_status),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .shift_in      (shift_in),
    .load          (load),
    .busy          (busy),
    .frame_done    (frame_done),
    .underrun      (underrun),
    .underrun_flag (underrun_flag),
    .frame_count   (frame_count)
  );

  always @(posedge clk) begin
    sr <= {sr[W-2:0], shift_in};
    if (load) data_out <= sr;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Scoreboard side: each load is followed by a data_out comparison.
  always @(negedge clk) begin
    cyc++;
    if (load_d) begin
      if (exp_q.size() > 0) check("data_out", 32'(data_out), 32'(exp_q.pop_front()));
      else                  check("load_without_expectation", 32'(exp_q.size()), 32'd1);
    end
    load_d = load;
    if (load) begin
      load_count++;
      prev_load_cyc = last_load_cyc;
      last_load_cyc = cyc;
    end
    if (frame_done) done_count++;
    if (underrun)   und_count++;
    if (track_busy && !busy) busy_drops++;
  end

  task automatic push_word(input logic [C-1:0] w);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = w;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n == 100) check("push_timeout", 32'(n), 32'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_loads(input int target, input string tag);
    int n = 0;
    while (load_count < target && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(tag, 32'(load_count), 32'(target));
  endtask

  initial begin
    logic [W-1:0] pat;
    int base, base_u;

    // Reset state
    #2 reset_n = 1'b0;
    #1;
    check("rst_shift_in", 32'(shift_in), 0);
    check("rst_load", 32'(load), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_underrun", 32'(underrun), 0);
    check("rst_flag", 32'(underrun_flag), 0);
    check("rst_count", 32'(frame_count), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1 check("rst_in_ready", 32'(in_ready), 1);

    // Single frame: preload both words, then enable and watch the bit stream
    pat = 16'hA53C;
    exp_q.push_back(16'hA53C);
    push_word(8'hA5);
    push_word(8'h3C);
    @(negedge clk);
    enable = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check($sformatf("stream_bit%0d", 15 - i), 32'(shift_in), 32'(pat[15-i]));
    end
    @(negedge clk);
    check("single_load", 32'(load), 1);
    check("single_frame_done", 32'(frame_done), 1);
    check("single_count", 32'(frame_count), 1);
    repeat (4) @(posedge clk);
    #1;
    check("single_done_pulses", 32'(done_count), 1);
    check("single_load_pulses", 32'(load_count), 1);

    // Back-to-back frames
    base = load_count;
    exp_q.push_back(16'hFF00);
    exp_q.push_back(16'h1234);
    push_word(8'hFF);
    push_word(8'h00);
    track_busy = 1'b1;
    push_word(8'h12);
    push_word(8'h34);
    wait_loads(base + 1, "b2b_first_load");
    wait_loads(base + 2, "b2b_second_load");
    track_busy = 1'b0;
    check("b2b_period", 32'(last_load_cyc - prev_load_cyc), 17);
    check("b2b_busy_drops", 32'(busy_drops), 0);
    check("b2b_count", 32'(frame_count), 3);

    // Underrun: a single word cannot fill the frame
    base   = load_count;
    base_u = und_count;
    push_word(8'hA5);
    for (int n = 0; n < 50 && und_count == base_u; n++) begin
      @(posedge clk);
      #1;
    end
    check("ur_pulse", 32'(und_count), 32'(base_u + 1));
    check("ur_flag", 32'(underrun_flag), 1);
    check("ur_idle", 32'(busy), 0);
    repeat (3) @(posedge clk);
    #1;
    check("ur_single_pulse", 32'(und_count), 32'(base_u + 1));
    check("ur_no_load", 32'(load_count), 32'(base));
    exp_q.push_back(16'h1122);
    push_word(8'h11);
    push_word(8'h22);
    wait_loads(base + 1, "ur_recovery_load");
    check("ur_flag_sticky", 32'(underrun_flag), 1);
    check("wrap_to_zero", 32'(frame_count), 0);
    @(negedge clk);
    clr_status = 1'b1;
    @(posedge clk);
    #1;
    clr_status = 1'b0;
    check("ur_flag_cleared", 32'(underrun_flag), 0);

    // Backpressure with enable low
    enable = 1'b0;
    base = load_count;
    exp_q.push_back(16'h1234);
    exp_q.push_back(16'h5678);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h12;
    check("bp_ready0", 32'(in_ready), 1);
    @(negedge clk);
    in_data = 8'h34;
    check("bp_ready1", 32'(in_ready), 1);
    @(negedge clk);
    in_data = 8'h56;
    check("bp_full", 32'(in_ready), 0);
    @(negedge clk);
    check("bp_full_hold", 32'(in_ready), 0);
    enable = 1'b1;
    @(negedge clk);
    check("bp_ready_back", 32'(in_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    push_word(8'h78);
    wait_loads(base + 2, "bp_loads");
    enable = 1'b0;

    // Reset in the middle of a frame
    push_word(8'hDE);
    push_word(8'hAD);
    @(negedge clk);
    enable = 1'b1;
    @(posedge clk);
    repeat (5) @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("mid_rst_shift_in", 32'(shift_in), 0);
    check("mid_rst_load", 32'(load), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_in_ready", 32'(in_ready), 0);
    check("mid_rst_count", 32'(frame_count), 0);
    check("mid_rst_flag", 32'(underrun_flag), 0);
    @(negedge clk);
    reset_n = 1'b1;
    #1 check("mid_rst_ready_after", 32'(in_ready), 1);
    repeat (3) @(posedge clk);
    #1 check("mid_rst_fifo_empty", 32'(busy), 0);
    base = load_count;
    exp_q.push_back(16'hBEEF);
    push_word(8'hBE);
    push_word(8'hEF);
    wait_loads(base + 1, "beef_load");
    check("wrap_count_1", 32'(frame_count), 1);

    // Counter wrap across further frames: 2,3,0,1
    for (int k = 0; k < 4; k++) begin
      logic [C-1:0] w1, w2;
      w1 = 8'h10 + 8'(k);
      w2 = 8'hC0 + 8'(k);
      base = load_count;
      exp_q.push_back({w1, w2});
      push_word(w1);
      push_word(w2);
      wait_loads(base + 1, $sformatf("wrap_load%0d", k));
      check($sformatf("wrap_count_k%0d", k), 32'(frame_count), 32'((k + 2) % 4));
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
